// File: rtl/otter_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : otter_mem_arbiter
//  Purpose  : Shares the single main-memory port between the I-cache line
//             fill requester and the D-cache fill/writeback requester.
//             Each line moves as a WORDS_PER_LINE word burst. Every returned
//             read word is pulsed on *_rvalid, and the end of the line is
//             pulsed on *_done. cache_stall freezes the pipeline while a
//             miss is outstanding.
//  Ports    : CLK, RST_N                 - clock, synchronous active-low reset
//             ic_req/ic_addr             - I-cache line request
//             ic_rdata/ic_rvalid/ic_done - I-cache fill data and strobes
//             dc_req/dc_we/dc_addr       - D-cache line request (we=writeback)
//             dc_wdata/dc_widx           - writeback word / its index
//             dc_rdata/dc_rvalid/dc_done - D-cache fill data and strobes
//             mem_req/mem_we/mem_addr    - memory word transfer
//             mem_wdata                  - memory write data
//             mem_ack/mem_rdata          - memory handshake and read word
//             cache_stall                - pipeline stall request
//  Revision : 1.0 - initial release
// ============================================================================
module otter_mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int WORDS_PER_LINE = 8
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic                              ic_req,
  input  logic [ADDR_W-1:0]                 ic_addr,
  output logic [DATA_W-1:0]                 ic_rdata,
  output logic                              ic_rvalid,
  output logic                              ic_done,
  input  logic                              dc_req,
  input  logic                              dc_we,
  input  logic [ADDR_W-1:0]                 dc_addr,
  input  logic [DATA_W-1:0]                 dc_wdata,
  output logic [$clog2(WORDS_PER_LINE)-1:0] dc_widx,
  output logic [DATA_W-1:0]                 dc_rdata,
  output logic                              dc_rvalid,
  output logic                              dc_done,
  output logic                              mem_req,
  output logic                              mem_we,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic [DATA_W-1:0]                 mem_wdata,
  input  logic                              mem_ack,
  input  logic [DATA_W-1:0]                 mem_rdata,
  output logic                              cache_stall
);

  localparam int                 c_CNT_W = $clog2(WORDS_PER_LINE);
  // Byte offset bits within a line: word index plus the 2 byte-in-word bits.
  localparam int                 c_OFF_W = c_CNT_W + 2;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WORDS_PER_LINE - 1);

  localparam logic [2:0] c_S_IDLE     = 3'd0;
  localparam logic [2:0] c_S_IC_BURST = 3'd1;
  localparam logic [2:0] c_S_DC_RD    = 3'd2;
  localparam logic [2:0] c_S_DC_WR    = 3'd3;
  localparam logic [2:0] c_S_DONE     = 3'd4;

  logic [2:0]         r_state;
  logic [2:0]         w_next_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [ADDR_W-1:0]  r_base;
  logic               r_last_dc;   // last grant went to D (0 = I)
  logic               r_gnt_dc;    // current/just-finished burst belongs to D
  logic [DATA_W-1:0]  r_ic_rdata;
  logic               r_ic_rvalid;
  logic [DATA_W-1:0]  r_dc_rdata;
  logic               r_dc_rvalid;

  logic               w_grant;
  logic               w_grant_dc;
  logic               w_in_burst;
  logic [ADDR_W-1:0]  w_req_addr;
  logic [ADDR_W-1:0]  w_line_base;
  logic [ADDR_W-1:0]  w_word_off;
  logic               w_unused;

  assign w_in_burst = (r_state == c_S_IC_BURST) || (r_state == c_S_DC_RD) ||
                      (r_state == c_S_DC_WR);

  // Line-aligned base of the requester being granted this cycle.
  assign w_req_addr  = w_grant_dc ? dc_addr : ic_addr;
  assign w_line_base = {w_req_addr[ADDR_W-1:c_OFF_W], {c_OFF_W{1'b0}}};
  assign w_word_off  = ADDR_W'({r_cnt, 2'b00});

  // The offset bits of the request address are discarded by design.
  assign w_unused = &{1'b0, w_req_addr[c_OFF_W-1:0]};

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic, including the round-robin grant decision
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_grant_dc   = 1'b0;
    case (r_state)
      c_S_IDLE: begin
        if (ic_req || dc_req) begin
          w_grant = 1'b1;
          // On a tie D wins unless D was the last one served.
          w_grant_dc = dc_req && (!ic_req || !r_last_dc);
          if (w_grant_dc) begin
            w_next_state = dc_we ? c_S_DC_WR : c_S_DC_RD;
          end else begin
            w_next_state = c_S_IC_BURST;
          end
        end
      end
      c_S_IC_BURST, c_S_DC_RD, c_S_DC_WR: begin
        if (mem_ack && (r_cnt == c_LAST)) begin
          w_next_state = c_S_DONE;
        end
      end
      c_S_DONE: begin
        // Never grant here: the finishing requester still has its request
        // up during this cycle.
        w_next_state = c_S_IDLE;
      end
      default: begin
        w_next_state = c_S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    ic_done  = 1'b0;
    dc_done  = 1'b0;
    case (r_state)
      c_S_IC_BURST, c_S_DC_RD: begin
        mem_req  = 1'b1;
        mem_addr = r_base + w_word_off;
      end
      c_S_DC_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = r_base + w_word_off;
      end
      c_S_DONE: begin
        ic_done = !r_gnt_dc;
        dc_done = r_gnt_dc;
      end
      default: begin
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Burst datapath: base/counter, grant history, registered read returns
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_cnt       <= '0;
      r_base      <= '0;
      r_last_dc   <= 1'b0;
      r_gnt_dc    <= 1'b0;
      r_ic_rdata  <= '0;
      r_ic_rvalid <= 1'b0;
      r_dc_rdata  <= '0;
      r_dc_rvalid <= 1'b0;
    end else begin
      r_ic_rvalid <= (r_state == c_S_IC_BURST) && mem_ack;
      r_dc_rvalid <= (r_state == c_S_DC_RD) && mem_ack;
      if ((r_state == c_S_IC_BURST) && mem_ack) begin
        r_ic_rdata <= mem_rdata;
      end
      if ((r_state == c_S_DC_RD) && mem_ack) begin
        r_dc_rdata <= mem_rdata;
      end

      if (w_grant) begin
        r_base    <= w_line_base;
        r_cnt     <= '0;
        r_last_dc <= w_grant_dc;
        r_gnt_dc  <= w_grant_dc;
      end else if (w_in_burst && mem_ack) begin
        // Power-of-two line length: the last ack wraps the count to 0.
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign ic_rdata    = r_ic_rdata;
  assign ic_rvalid   = r_ic_rvalid;
  assign dc_rdata    = r_dc_rdata;
  assign dc_rvalid   = r_dc_rvalid;
  assign dc_widx     = r_cnt;
  assign mem_wdata   = dc_wdata;
  // Dropping stall in DONE lets the pipeline advance exactly once per line.
  assign cache_stall = (ic_req || dc_req) && (r_state != c_S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_otter_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_otter_mem_arbiter
//  Purpose  : Directed bench for otter_mem_arbiter. Acts as both caches and
//             the memory. Read words are pushed to a scoreboard queue when
//             acked and popped when the granted *_rvalid appears.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_otter_mem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int WPL = 8;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          ic_req;
  logic [AW-1:0] ic_addr;
  logic [DW-1:0] ic_rdata;
  logic          ic_rvalid;
  logic          ic_done;
  logic          dc_req;
  logic          dc_we;
  logic [AW-1:0] dc_addr;
  logic [DW-1:0] dc_wdata;
  logic [2:0]    dc_widx;
  logic [DW-1:0] dc_rdata;
  logic          dc_rvalid;
  logic          dc_done;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          cache_stall;

  int            checks = 0;
  int            errors = 0;
  logic [31:0]   rd_q[$];

  always #5 CLK = ~CLK;

  otter_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .WORDS_PER_LINE(WPL)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata),
    .ic_rvalid(ic_rvalid), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_widx(dc_widx), .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid),
    .dc_done(dc_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .cache_stall(cache_stall)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wpat(input logic [2:0] idx);
    return 32'hC0DE_0000 + 32'(idx);
  endfunction

  // Serve one line burst for the requester the bench expects to be granted.
  // exp_idle: IDLE cycles expected before the grant shows up.
  // late_ic_at: word index at which ic_req rises mid-burst (-1 = never).
  task automatic do_burst(input bit is_dc, input bit we, input logic [31:0] addr,
                          input int period, input int exp_idle,
                          input int late_ic_at);
    logic [31:0] base;
    logic [31:0] exp_d;
    int          k, wc, idle_n, guard;
    bit          rv_due, done_seen;
    base      = addr & ~32'h1F;
    k         = 0;
    wc        = 0;
    idle_n    = 0;
    guard     = 0;
    rv_due    = 1'b0;
    done_seen = 1'b0;
    @(negedge CLK);
    while (mem_req !== 1'b1 && idle_n < 4) begin
      check("idle_stall", {31'b0, cache_stall}, {31'b0, ic_req | dc_req});
      @(negedge CLK);
      idle_n++;
    end
    check("grant_latency", 32'(idle_n), 32'(exp_idle));
    check("grant_seen", {31'b0, mem_req}, 32'd1);
    while (!done_seen && guard < 200) begin
      guard++;
      check("ic_rvalid", {31'b0, ic_rvalid}, {31'b0, rv_due && !is_dc});
      check("dc_rvalid", {31'b0, dc_rvalid}, {31'b0, rv_due && is_dc});
      if (rv_due) begin
        exp_d = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hxxxx_xxxx;
        check("rdata", is_dc ? dc_rdata : ic_rdata, exp_d);
      end
      rv_due = 1'b0;
      if (k == WPL) begin
        check("ic_done", {31'b0, ic_done}, {31'b0, !is_dc});
        check("dc_done", {31'b0, dc_done}, {31'b0, is_dc});
        check("done_mem_req", {31'b0, mem_req}, 32'd0);
        check("done_stall", {31'b0, cache_stall}, 32'd0);
        done_seen = 1'b1;
        if (is_dc) dc_req = 1'b0;
        else       ic_req = 1'b0;
        mem_ack = 1'b0;
      end else begin
        if (k == late_ic_at) ic_req = 1'b1;
        if (we) dc_wdata = wpat(dc_widx);
        #1;
        check("mem_req", {31'b0, mem_req}, 32'd1);
        check("mem_we", {31'b0, mem_we}, {31'b0, we});
        check("mem_addr", mem_addr, base + 32'(k) * 32'd4);
        check("dc_widx", {29'b0, dc_widx}, 32'(k));
        check("burst_done", {30'b0, ic_done, dc_done}, 32'd0);
        check("burst_stall", {31'b0, cache_stall}, 32'd1);
        if (we) check("mem_wdata", mem_wdata, wpat(3'(k)));
        wc++;
        mem_rdata = $urandom;
        if (wc >= period) begin
          wc      = 0;
          mem_ack = 1'b1;
          if (!we) begin
            rd_q.push_back(mem_rdata);
            rv_due = 1'b1;
          end
          k++;
        end else begin
          mem_ack = 1'b0;
        end
        @(negedge CLK);
      end
    end
    check("done_seen", {31'b0, done_seen}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RST_N     = 1'b0;
    ic_req    = 1'b0;
    ic_addr   = '0;
    dc_req    = 1'b0;
    dc_we     = 1'b0;
    dc_addr   = '0;
    dc_wdata  = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    repeat (2) @(negedge CLK);

    // Reset state
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_rvalid", {30'b0, ic_rvalid, dc_rvalid}, 32'd0);
    check("rst_done", {30'b0, ic_done, dc_done}, 32'd0);
    check("rst_widx", {29'b0, dc_widx}, 32'd0);
    check("rst_ic_rdata", ic_rdata, 32'd0);
    check("rst_dc_rdata", dc_rdata, 32'd0);
    check("rst_stall", {31'b0, cache_stall}, 32'd0);
    RST_N = 1'b1;

    // Stray acks in IDLE with nobody requesting
    for (int i = 0; i < 3; i++) begin
      mem_ack   = 1'b1;
      mem_rdata = $urandom;
      @(negedge CLK);
      check("stray_mem_req", {31'b0, mem_req}, 32'd0);
      check("stray_rvalid", {30'b0, ic_rvalid, dc_rvalid}, 32'd0);
      check("stray_done", {30'b0, ic_done, dc_done}, 32'd0);
      check("stray_widx", {29'b0, dc_widx}, 32'd0);
    end
    mem_ack = 1'b0;

    // I-fill, ack every cycle, unaligned request address
    ic_addr = 32'h0000_1014;
    ic_req  = 1'b1;
    do_burst(1'b0, 1'b0, 32'h0000_1014, 1, 0, -1);

    // D writeback with two wait states per word
    dc_addr = 32'h0000_2000;
    dc_we   = 1'b1;
    dc_req  = 1'b1;
    do_burst(1'b1, 1'b1, 32'h0000_2000, 3, 1, -1);

    // Reset in the middle of a writeback at word 3
    dc_addr = 32'h0000_3000;
    dc_we   = 1'b1;
    dc_req  = 1'b1;
    mem_ack = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge CLK);
      dc_wdata = $urandom;
      if (mem_req === 1'b1 && dc_widx === 3'd3) break;
    end
    check("pre_rst_widx", {29'b0, dc_widx}, 32'd3);
    RST_N   = 1'b0;
    mem_ack = 1'b0;
    @(negedge CLK);
    check("midrst_mem_req", {31'b0, mem_req}, 32'd0);
    check("midrst_widx", {29'b0, dc_widx}, 32'd0);
    check("midrst_mem_addr", mem_addr, 32'd0);
    check("midrst_done1", {30'b0, ic_done, dc_done}, 32'd0);
    @(negedge CLK);
    check("midrst_done2", {30'b0, ic_done, dc_done}, 32'd0);

    // Tie after reset: D first, then I
    RST_N   = 1'b1;
    dc_we   = 1'b0;
    dc_addr = 32'h0000_4000;
    ic_addr = 32'h0000_5008;
    ic_req  = 1'b1;
    dc_req  = 1'b1;
    do_burst(1'b1, 1'b0, 32'h0000_4000, 1, 0, -1);
    do_burst(1'b0, 1'b0, 32'h0000_5008, 2, 1, -1);

    // Second tie: last grant was I, so D again
    dc_addr = 32'h0000_6000;
    ic_addr = 32'h0000_7030;
    ic_req  = 1'b1;
    dc_req  = 1'b1;
    do_burst(1'b1, 1'b0, 32'h0000_6000, 2, 1, -1);
    do_burst(1'b0, 1'b0, 32'h0000_7030, 1, 1, -1);

    // Late I request during a D fill waits for the fill to finish
    dc_addr = 32'h0000_8000;
    ic_addr = 32'h0000_9000;
    dc_req  = 1'b1;
    do_burst(1'b1, 1'b0, 32'h0000_8000, 1, 1, 4);
    do_burst(1'b0, 1'b0, 32'h0000_9000, 1, 1, -1);

    @(negedge CLK);
    check("end_mem_req", {31'b0, mem_req}, 32'd0);
    check("end_queue", 32'(rd_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/otter_mem_arbiter.md
Name: otter_mem_arbiter

Overview:
- Arbitrates the single main-memory port between the I-cache line-fill requester and the D-cache fill/writeback requester of the pipelined OTTER.
- Sequences each line as a word burst and pulses per-word valid and end-of-line done strobes.
- Drives cache_stall into the hazard/stall logic so the pipeline freezes while any cache miss is outstanding.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, word width.
- WORDS_PER_LINE, 8, words per burst; power of 2, ≥2.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  synchronous active-low reset.
- ic_req  in  1  I-cache miss request; held until ic_done.
- ic_addr  in  ADDR_W  I-cache line address.
- ic_rdata  out  DATA_W  registered fill word.
- ic_rvalid  out  1  ic_rdata valid this cycle.
- ic_done  out  1  one-cycle end-of-line pulse.
- dc_req  in  1  D-cache request; held until dc_done.
- dc_we  in  1  1 = writeback burst, 0 = fill burst; stable while dc_req is high.
- dc_addr  in  ADDR_W  D-cache line address.
- dc_wdata  in  DATA_W  writeback word at index dc_widx.
- dc_widx  out  clog2(WORDS_PER_LINE)  current word index.
- dc_rdata  out  DATA_W  registered fill word.
- dc_rvalid  out  1  dc_rdata valid this cycle.
- dc_done  out  1  one-cycle end-of-line pulse.
- mem_req  out  1  memory transfer active.
- mem_we  out  1  write transfer.
- mem_addr  out  ADDR_W  current word address.
- mem_wdata  out  DATA_W  equals dc_wdata (combinational).
- mem_ack  in  1  memory accepted/returned one word this cycle.
- mem_rdata  in  DATA_W  read word, valid with mem_ack.
- cache_stall  out  1  pipeline stall request.

Behaviour:
- States: IDLE, IC_BURST, DC_RD, DC_WR, DONE.
- Reset (RST_N=0 at an edge):
  - state=IDLE, word counter=0, last_grant=I.
  - All outputs 0: data/valid/done/mem_* low, mem_addr 0.
  - Reset mid-burst aborts the burst. mem_req is low after that edge. No done pulse.
- IDLE grant:
  - Only one requester high: grant it.
  - Both high: grant the one not in last_grant (round-robin). After reset, D wins the first tie.
  - Grant takes effect next edge. last_grant updates at the grant.
- Latching at grant:
  - Base address latched with its low log2(WORDS_PER_LINE)+2 bits forced to 0.
  - dc_we latched and selects DC_WR or DC_RD.
  - Counter cleared.
- Burst states:
  - mem_req=1; mem_we=1 only in DC_WR.
  - mem_addr = base + 4·cnt.
  - dc_widx = cnt in every state (0 outside bursts).
  - Each mem_ack: cnt increments.
  - On a read burst, the next cycle the granted *_rdata = captured mem_rdata and *_rvalid=1 for exactly one cycle. The other requester's valid stays 0.
  - Ack on cnt = WORDS_PER_LINE-1: cnt wraps to 0, state→DONE.
  - No mem_ack: hold state and address indefinitely, with no timeout.
- DONE (one cycle):
  - mem_req=0. Granted *_done=1. No new grant is taken.
  - For a read burst, the final rvalid coincides with done.
  - Next state IDLE.
  - A requester re-asserting in the cycle after done is treated as a new request.
- cache_stall = (ic_req | dc_req) & ~(state==DONE). It falls in the DONE cycle so the pipeline advances once the line is complete. If the other requester is pending, stall re-asserts the following cycle.
- Requests from the non-granted side are ignored but not dropped. They must stay high and are serviced after the current burst.
- mem_ack outside a burst state is ignored.

Test Plan:
- Reset: RST_N=0 for 2 cycles during a DC_WR burst at cnt=3 → next cycle mem_req=0, dc_widx=0, no dc_done. A following ic_req/dc_req tie grants D first.
- I-fill: ic_req=1, ic_addr=0x0000_1014, mem_ack every cycle → mem_addr 0x1000,0x1004,…,0x101C. Eight ic_rvalid pulses carry the mem_rdata values in order. ic_done fires the cycle after the 8th ack. cache_stall is 0 in that cycle.
- Writeback with wait states: dc_req=1, dc_we=1, dc_addr=0x2000, mem_ack every 3rd cycle → mem_we=1. Each address is held until its ack. mem_wdata tracks dc_wdata for dc_widx=0..7. No dc_rvalid. One dc_done.
- Tie round-robin: ic_req and dc_req rise together after reset → D burst, then I burst. Repeat the tie → D again (last_grant=I). Total 4 done pulses, correctly routed.
- Late requester: ic_req rises at cnt=4 of a D fill → I is not granted until IDLE after dc_done. cache_stall stays 1 except the single DONE cycle.
- Stray ack: mem_ack=1 in IDLE with no requests → no state change, no valid/done pulses.
